// File: rtl/status_if.sv
// Operand, control and status bundle between an ALU datapath and status_unit.
interface status_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [2:0]       op_code;
    logic             flag_we;
    logic             push;
    logic             pop;
    logic             sticky_clr;

    logic             zero;
    logic             carry;
    logic             overflow;
    logic             negative;
    logic             sticky_ov;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;
    logic [CW-1:0]    stack_count;

    modport master (
        output a, b, result, op_code, flag_we, push, pop, sticky_clr,
        input  zero, carry, overflow, negative, sticky_ov,
               stack_full, stack_empty, stack_err, stack_count
    );

    modport slave (
        input  a, b, result, op_code, flag_we, push, pop, sticky_clr,
        output zero, carry, overflow, negative, sticky_ov,
               stack_full, stack_empty, stack_err, stack_count
    );
endinterface

// File: rtl/status_unit.sv
// ALU status flag register with sticky overflow and a LIFO flag-save stack.
module status_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    status_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [CW-1:0]    ZERO_C   = {CW{1'b0}};

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_NEG  = 3'b100,
        OP_CMP  = 3'b101,
        OP_PASS = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    // Flag vector layout is {negative, overflow, carry, zero}.
    logic [3:0]    flags_q, flags_d;
    logic          sticky_q, sticky_d;
    logic          err_q, err_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    stack_q [DEPTH];

    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] diff_c;
    logic             n_c, v_c, c_c, z_c, upd_c;
    logic             full_c, empty_c, push_ok_c, pop_ok_c, load_c;
    logic [CW-1:0]    top_c;
    logic [IW-1:0]    wr_idx_c, rd_idx_c;

    always_comb begin
        sum_c  = {1'b0, bus.a} + {1'b0, bus.b};
        diff_c = bus.a - bus.b;
        n_c    = bus.result[WIDTH-1];
        z_c    = (bus.result == ZERO_W);
        c_c    = flags_q[1];
        v_c    = flags_q[2];
        upd_c  = 1'b1;
        case (op_e'(bus.op_code))
            OP_ADD: begin
                c_c = sum_c[WIDTH];
                v_c = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                      (bus.result[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                c_c = (bus.a >= bus.b);
                v_c = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                      (bus.result[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_INC: begin
                c_c = (bus.a == ALL_ONES);
                v_c = (bus.a == MAX_POS);
            end
            OP_DEC: begin
                c_c = (bus.a != ZERO_W);
                v_c = (bus.a == MIN_NEG);
            end
            OP_NEG: begin
                c_c = (bus.a != ZERO_W);
                v_c = (bus.a == MIN_NEG);
            end
            OP_CMP: begin
                c_c = (bus.a >= bus.b);
                v_c = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                      (diff_c[WIDTH-1] != bus.a[WIDTH-1]);
                z_c = (bus.a == bus.b);
                n_c = diff_c[WIDTH-1];
            end
            OP_PASS: ;
            default: upd_c = 1'b0;
        endcase
    end

    // Any pop request (even a rejected one) suppresses the computed-flag load.
    always_comb begin
        full_c    = (count_q == DEPTH_C);
        empty_c   = (count_q == ZERO_C);
        push_ok_c = bus.push & ~bus.pop & ~full_c;
        pop_ok_c  = bus.pop & ~bus.push & ~empty_c;
        load_c    = bus.flag_we & ~bus.pop & upd_c;
        err_d     = (bus.push & bus.pop) | (bus.push & full_c) | (bus.pop & empty_c);
        top_c     = count_q - ONE_C;
        wr_idx_c  = count_q[IW-1:0];
        rd_idx_c  = top_c[IW-1:0];

        flags_d = flags_q;
        if (pop_ok_c) begin
            flags_d = stack_q[rd_idx_c];
        end else if (load_c) begin
            flags_d = {n_c, v_c, c_c, z_c};
        end

        sticky_d = (load_c & v_c) | (sticky_q & ~bus.sticky_clr);

        count_d = count_q;
        if (push_ok_c) begin
            count_d = count_q + ONE_C;
        end else if (pop_ok_c) begin
            count_d = top_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q  <= 4'b0000;
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= ZERO_C;
        end else begin
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    // Stack storage is qualified by count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            stack_q[wr_idx_c] <= flags_q;
        end
    end

    assign bus.negative    = flags_q[3];
    assign bus.overflow    = flags_q[2];
    assign bus.carry       = flags_q[1];
    assign bus.zero        = flags_q[0];
    assign bus.sticky_ov   = sticky_q;
    assign bus.stack_err   = err_q;
    assign bus.stack_count = count_q;
    assign bus.stack_full  = (count_q == DEPTH_C);
    assign bus.stack_empty = (count_q == ZERO_C);
endmodule

// File: tb/tb_status_unit.sv
// Directed bench for status_unit: flag computation, sticky overflow, stack and reset.
module tb_status_unit;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, INC = 3'b010, DEC = 3'b011,
                           NEG = 3'b100, CMP = 3'b101, PAS = 3'b110, NOP = 3'b111;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    status_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    status_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {bus.negative, bus.overflow, bus.carry, bus.zero};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; sample 1 time unit after the rising edge.
    task automatic step(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] res, input logic we, input logic psh,
                        input logic pp, input logic clr);
        @(negedge clk);
        bus.op_code    = op;
        bus.a          = a;
        bus.b          = b;
        bus.result     = res;
        bus.flag_we    = we;
        bus.push       = psh;
        bus.pop        = pp;
        bus.sticky_clr = clr;
        @(posedge clk);
        #1;
        bus.flag_we    = 1'b0;
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
        bus.sticky_clr = 1'b0;
    endtask

    task automatic idle();
        step(NOP, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.op_code = NOP; bus.a = '0; bus.b = '0; bus.result = '0;
        bus.flag_we = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.sticky_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags",  {4'h0, flags()}, 8'h00);
        chk("rst_sticky", {7'h0, bus.sticky_ov}, 8'h00);
        chk("rst_err",    {7'h0, bus.stack_err}, 8'h00);
        chk("rst_count",  {5'h0, bus.stack_count}, 8'h00);
        chk("rst_empty",  {7'h0, bus.stack_empty}, 8'h01);
        chk("rst_full",   {7'h0, bus.stack_full}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Flags are {N,V,C,Z}
        step(ADD, 8'h7F, 8'h01, 8'h80, 1, 0, 0, 0);
        chk("add_ovf_flags", {4'h0, flags()}, 8'h0C);
        chk("add_ovf_sticky", {7'h0, bus.sticky_ov}, 8'h01);
        step(SUB, 8'h05, 8'h05, 8'h00, 1, 0, 0, 0);
        chk("sub_eq_flags", {4'h0, flags()}, 8'h03);
        step(PAS, 8'h00, 8'h00, 8'h01, 1, 0, 0, 0);
        chk("pass_hold_cv", {4'h0, flags()}, 8'h02);
        step(INC, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 0);
        chk("inc_wrap_flags", {4'h0, flags()}, 8'h03);
        step(DEC, 8'h80, 8'h00, 8'h7F, 1, 0, 0, 0);
        chk("dec_minneg_flags", {4'h0, flags()}, 8'h06);
        step(NOP, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
        chk("nop_we_hold", {4'h0, flags()}, 8'h06);
        step(ADD, 8'hFF, 8'h01, 8'h00, 0, 0, 0, 0);
        chk("we0_hold", {4'h0, flags()}, 8'h06);
        step(CMP, 8'h03, 8'h05, 8'hFF, 1, 0, 0, 0);
        chk("cmp_lt_flags", {4'h0, flags()}, 8'h08);
        step(ADD, 8'hFF, 8'h01, 8'h00, 1, 0, 0, 0);
        chk("add_carry_flags", {4'h0, flags()}, 8'h03);
        step(NEG, 8'h80, 8'h00, 8'h80, 1, 0, 0, 0);
        chk("neg_minneg_flags", {4'h0, flags()}, 8'h0E);

        step(NOP, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        chk("clr_alone", {7'h0, bus.sticky_ov}, 8'h00);
        step(ADD, 8'h7F, 8'h01, 8'h80, 1, 0, 0, 0);
        step(ADD, 8'h01, 8'h01, 8'h02, 1, 0, 0, 0);
        chk("add_noovf_flags", {4'h0, flags()}, 8'h00);
        chk("sticky_kept", {7'h0, bus.sticky_ov}, 8'h01);
        step(ADD, 8'h7F, 8'h01, 8'h80, 1, 0, 0, 1);
        chk("set_beats_clr", {7'h0, bus.sticky_ov}, 8'h01);
        step(NOP, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        chk("clr_after", {7'h0, bus.sticky_ov}, 8'h00);
        step(NEG, 8'h80, 8'h00, 8'h80, 1, 0, 0, 1);
        chk("pre_stack_flags", {4'h0, flags()}, 8'h0E);

        // Each push saves the old flags while loading new ones.
        step(ADD, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0);
        chk("push1_flags", {4'h0, flags()}, 8'h03);
        chk("push1_count", {5'h0, bus.stack_count}, 8'h01);
        step(CMP, 8'h03, 8'h05, 8'h00, 1, 1, 0, 0);
        step(DEC, 8'h80, 8'h00, 8'h7F, 1, 1, 0, 0);
        chk("push3_full", {7'h0, bus.stack_full}, 8'h00);
        step(ADD, 8'h01, 8'h01, 8'h02, 1, 1, 0, 0);
        chk("push4_flags", {4'h0, flags()}, 8'h00);
        chk("push4_full", {7'h0, bus.stack_full}, 8'h01);
        chk("push4_err", {7'h0, bus.stack_err}, 8'h00);
        step(NOP, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
        chk("push5_err", {7'h0, bus.stack_err}, 8'h01);
        chk("push5_count", {5'h0, bus.stack_count}, 8'h04);
        idle();
        chk("err_one_cycle", {7'h0, bus.stack_err}, 8'h00);
        step(NOP, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
        chk("pop1_flags", {4'h0, flags()}, 8'h06);
        chk("pop1_count", {5'h0, bus.stack_count}, 8'h03);
        step(NOP, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
        chk("pop2_flags", {4'h0, flags()}, 8'h08);
        step(NOP, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
        chk("pop3_flags", {4'h0, flags()}, 8'h03);
        step(NOP, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
        chk("pop4_flags", {4'h0, flags()}, 8'h0E);
        chk("pop4_empty", {7'h0, bus.stack_empty}, 8'h01);
        step(NOP, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
        chk("pop5_err", {7'h0, bus.stack_err}, 8'h01);
        chk("pop5_flags", {4'h0, flags()}, 8'h0E);

        // Pop beats flag_we, and a restored V=1 does not set sticky.
        step(NOP, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1);
        chk("push_one_count", {5'h0, bus.stack_count}, 8'h01);
        step(ADD, 8'h01, 8'h01, 8'h02, 1, 0, 1, 0);
        chk("pop_wins_flags", {4'h0, flags()}, 8'h0E);
        chk("pop_no_sticky", {7'h0, bus.sticky_ov}, 8'h00);
        step(NOP, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0);
        chk("pushpop_err", {7'h0, bus.stack_err}, 8'h01);
        chk("pushpop_count", {5'h0, bus.stack_count}, 8'h00);

        // Mid-cycle reset while push and pop are pending.
        step(NOP, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
        step(NOP, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
        chk("pre_rst_count", {5'h0, bus.stack_count}, 8'h02);
        @(negedge clk);
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {4'h0, flags()}, 8'h00);
        chk("async_rst_count", {5'h0, bus.stack_count}, 8'h00);
        chk("async_rst_empty", {7'h0, bus.stack_empty}, 8'h01);
        @(negedge clk);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        rst_n    = 1'b1;
        idle();
        chk("post_rst_err", {7'h0, bus.stack_err}, 8'h00);
        chk("post_rst_count", {5'h0, bus.stack_count}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
